// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if
//   Bundles the producer-side (mux result) and consumer-side (register
//   file / display) handshake signals of the ALU result stage.
//   Ports/signals:
//     in_valid, in_ready          producer handshake
//     in_result, in_sel, in_carry mux output, its select code, adder carry
//     in_acc_en                   load result into accumulator on accept
//     out_valid, out_ready        consumer handshake
//     out_result, out_sel         head entry data and opcode
//     out_zero, out_neg, out_carry head entry status flags
//   Modports:
//     master - environment side (drives in_*, out_ready)
//     slave  - the result stage (drives in_ready, out_*)
interface alu_result_stage_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [2:0]       in_sel;
  logic             in_carry;
  logic             in_acc_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_sel;
  logic             out_zero;
  logic             out_neg;
  logic             out_carry;

  modport master (
    output in_valid, in_result, in_sel, in_carry, in_acc_en, out_ready,
    input  in_ready, out_valid, out_result, out_sel, out_zero, out_neg, out_carry
  );

  modport slave (
    input  in_valid, in_result, in_sel, in_carry, in_acc_en, out_ready,
    output in_ready, out_valid, out_result, out_sel, out_zero, out_neg, out_carry
  );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Registered output stage behind the ALU result-select mux. Each accepted
//   result is stored with its opcode and status flags in a small FIFO that
//   the consumer drains through a valid/ready handshake. An accumulator
//   feeds back to the ALU as operand A; op_count counts retired entries.
//   Ports:
//     clk       system clock, rising edge
//     rst_n     asynchronous active-low reset
//     bus       alu_result_stage_if slave view (producer + consumer handshake)
//     acc       accumulator (operand A feedback)
//     op_count  popped entries, modulo 2^CNT_W
module alu_result_stage #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_result_stage_if.slave  bus,
  output logic [WIDTH-1:0]   acc,
  output logic [CNT_W-1:0]   op_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Carry is only meaningful for the add/sub opcodes (3'b000, 3'b001).
  function automatic logic carry_mask(input logic [2:0] sel, input logic carry);
    return (sel[2:1] == 2'b00) ? carry : 1'b0;
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_idx, rd_idx;
  logic             full, vld_p1, in_rdy, push, pop;

  logic [WIDTH-1:0] res_p1   [DEPTH];
  logic [2:0]       sel_p1   [DEPTH];
  logic             zero_p1  [DEPTH];
  logic             neg_p1   [DEPTH];
  logic             carry_p1 [DEPTH];

  assign wr_idx = wr_ptr[PTR_W-1:0];
  assign rd_idx = rd_ptr[PTR_W-1:0];
  assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
  assign vld_p1 = (wr_ptr != rd_ptr);
  assign in_rdy = !full;
  assign push   = bus.in_valid && in_rdy;
  assign pop    = vld_p1 && bus.out_ready;

  // Control state: pointers, accumulator, retired-op counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      acc      <= '0;
      op_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (bus.in_acc_en) acc <= bus.in_result;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        op_count <= op_count + 1'b1;
      end
    end
  end

  // Stage p0 -> p1: entry capture; storage needs no reset since reads are
  // masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      res_p1[wr_idx]   <= bus.in_result;
      sel_p1[wr_idx]   <= bus.in_sel;
      zero_p1[wr_idx]  <= (bus.in_result == '0);
      neg_p1[wr_idx]   <= bus.in_result[WIDTH-1];
      carry_p1[wr_idx] <= carry_mask(bus.in_sel, bus.in_carry);
    end
  end

  // Head entry drives the outputs directly; forced to zero while empty so
  // stale contents never show after reset or a drain.
  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = vld_p1;
  assign bus.out_result = vld_p1 ? res_p1[rd_idx]   : '0;
  assign bus.out_sel    = vld_p1 ? sel_p1[rd_idx]   : 3'b000;
  assign bus.out_zero   = vld_p1 ? zero_p1[rd_idx]  : 1'b0;
  assign bus.out_neg    = vld_p1 ? neg_p1[rd_idx]   : 1'b0;
  assign bus.out_carry  = vld_p1 ? carry_p1[rd_idx] : 1'b0;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] acc;
  logic [7:0] op_count;
  int         checks = 0;
  int         failures = 0;

  alu_result_stage_if #(.WIDTH(4)) bus ();

  alu_result_stage #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .acc      (acc),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] r, input logic [2:0] s,
                       input logic c, input logic a);
    bus.in_valid  = v;
    bus.in_result = r;
    bus.in_sel    = s;
    bus.in_carry  = c;
    bus.in_acc_en = a;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    drive(1'b1, 4'hF, 3'b000, 1'b1, 1'b1);
    tick(); tick();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_acc", 32'(acc), 0);
    check("rst_op_count", 32'(op_count), 0);
    rst_n = 1'b1;
    drive(1'b0, 4'hX, 3'bXXX, 1'bX, 1'bX);
    tick();
    check("rel_out_valid", 32'(bus.out_valid), 0);
    check("rel_in_ready", 32'(bus.in_ready), 1);
    check("rel_acc_x_idle", 32'(acc), 0);

    // Single op: zero result, carry masked for sel 010
    drive(1'b1, 4'h0, 3'b010, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'h0, 3'b000, 1'b0, 1'b0);
    check("single_valid", 32'(bus.out_valid), 1);
    check("single_zero", 32'(bus.out_zero), 1);
    check("single_neg", 32'(bus.out_neg), 0);
    check("single_carry", 32'(bus.out_carry), 0);
    check("single_sel", 32'(bus.out_sel), 2);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("single_drained", 32'(bus.out_valid), 0);
    check("single_opcnt", 32'(op_count), 1);
    check("empty_result", 32'(bus.out_result), 0);

    // Fill and drain
    drive(1'b1, 4'h9, 3'b000, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'h3, 3'b101, 1'b1, 1'b0);
    tick();
    check("full_in_ready", 32'(bus.in_ready), 0);
    check("full_head", 32'(bus.out_result), 32'h9);
    check("full_neg", 32'(bus.out_neg), 1);
    check("full_carry", 32'(bus.out_carry), 1);
    drive(1'b1, 4'h5, 3'b011, 1'b0, 1'b0);
    tick();
    check("held_head", 32'(bus.out_result), 32'h9);
    check("held_in_ready", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    tick();
    check("pop9_head", 32'(bus.out_result), 32'h3);
    check("pop9_carry_masked", 32'(bus.out_carry), 0);
    check("pop9_opcnt", 32'(op_count), 2);
    check("pop9_in_ready", 32'(bus.in_ready), 1);
    tick();
    check("pop3_head5", 32'(bus.out_result), 32'h5);
    check("pop3_sel", 32'(bus.out_sel), 3);
    check("pop3_opcnt", 32'(op_count), 3);

    // Simultaneous push/pop at count=1
    drive(1'b1, 4'h6, 3'b001, 1'b1, 1'b0);
    tick();
    check("pp1_head", 32'(bus.out_result), 32'h6);
    check("pp1_carry", 32'(bus.out_carry), 1);
    check("pp1_in_ready", 32'(bus.in_ready), 1);
    drive(1'b1, 4'hA, 3'b100, 1'b0, 1'b0);
    tick();
    check("pp2_head", 32'(bus.out_result), 32'hA);
    check("pp2_opcnt", 32'(op_count), 5);
    drive(1'b0, 4'h0, 3'b000, 1'b0, 1'b0);
    tick();
    check("pp_empty", 32'(bus.out_valid), 0);
    tick(); tick();
    check("empty_ready_opcnt", 32'(op_count), 6);
    bus.out_ready = 1'b0;

    // Accumulator
    drive(1'b1, 4'h7, 3'b110, 1'b0, 1'b1);
    tick();
    check("acc_load7", 32'(acc), 32'h7);
    drive(1'b1, 4'h2, 3'b110, 1'b0, 1'b0);
    tick();
    check("acc_noen", 32'(acc), 32'h7);
    drive(1'b1, 4'hD, 3'b110, 1'b0, 1'b1);
    tick();
    check("acc_full_blocked", 32'(acc), 32'h7);
    check("acc_full_head", 32'(bus.out_result), 32'h7);
    drive(1'b0, 4'hC, 3'b110, 1'b0, 1'b1);
    tick();
    check("acc_novalid", 32'(acc), 32'h7);

    // Async reset while full
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid_drop", 32'(bus.out_valid), 0);
    check("arst_acc", 32'(acc), 0);
    check("arst_opcnt", 32'(op_count), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_no_stale", 32'(bus.out_valid), 0);
    check("arst_result", 32'(bus.out_result), 0);
    check("arst_in_ready", 32'(bus.in_ready), 1);

    // Streaming: 300 pops, order preserved, counter wraps
    bus.out_ready = 1'b1;
    drive(1'b1, 4'h0, 3'b111, 1'b0, 1'b0);
    tick();
    for (int i = 1; i <= 300; i++) begin
      check("stream_order", 32'(bus.out_result), 32'((i - 1) & 15));
      bus.in_result = 4'(i);
      tick();
    end
    drive(1'b0, 4'h0, 3'b000, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    check("wrap_opcnt", 32'(op_count), 44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
